// File: rtl/lm75_i2c_target_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lm75_i2c_target_pkg
// Description : Shared FSM state encoding, register pointer constants and
//               9-bit register byte-format helpers for the LM75 I2C target.
// Revision    : 1.0 - initial release
// ============================================================================
package lm75_i2c_target_pkg;

    localparam int STATE_W = 4;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_ADDR     = 4'd1;
    localparam state_t ST_ADDR_ACK = 4'd2;
    localparam state_t ST_PTR      = 4'd3;
    localparam state_t ST_PTR_ACK  = 4'd4;
    localparam state_t ST_WDATA    = 4'd5;
    localparam state_t ST_WACK     = 4'd6;
    localparam state_t ST_RDATA    = 4'd7;
    localparam state_t ST_RACK     = 4'd8;

    localparam logic [1:0] PTR_TEMP  = 2'd0;
    localparam logic [1:0] PTR_CONF  = 2'd1;
    localparam logic [1:0] PTR_THYST = 2'd2;
    localparam logic [1:0] PTR_TOS   = 2'd3;

    // Byte 0 carries the upper eight bits, byte 1 carries the LSB in bit 7.
    function automatic logic [7:0] reg9_byte(input logic [8:0] value, input logic idx);
        return idx ? {value[0], 7'b0} : value[8:1];
    endfunction

    // Rebuild a 9-bit register from its two bus bytes.
    function automatic logic [8:0] reg9_pack(input logic [7:0] b0, input logic [7:0] b1);
        return {b0, b1[7]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lm75_i2c_target_bus_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_sync
// Description : Two-flop synchronisers on SCL/SDA plus edge detection that
//               yields SCL rise/fall strobes and START/STOP conditions.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d;
    logic       sda_prev_q, sda_prev_d;
    logic       w_scl_s;

    // Shift the raw pad levels through the synchroniser and keep last value.
    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_i};
        sda_sync_d = {sda_sync_q[0], sda_i};
        scl_prev_d = scl_sync_q[1];
        sda_prev_d = sda_sync_q[1];
    end

    // Idle bus level is high, so every stage resets to 1 to avoid false edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign w_scl_s   = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = w_scl_s & ~scl_prev_q;
    assign scl_fall  = ~w_scl_s & scl_prev_q;
    // SCL must be high on both sides of the SDA edge to count as START/STOP.
    assign start_det = w_scl_s & scl_prev_q & ~sda_s & sda_prev_q;
    assign stop_det  = w_scl_s & scl_prev_q & sda_s & ~sda_prev_q;

endmodule
`default_nettype wire

// File: rtl/lm75_i2c_target.sv
`default_nettype none
// ============================================================================
// Module      : lm75_i2c_target
// Description : LM75-style temperature sensor I2C target: pointer register,
//               TEMP/CONF/THYST/TOS register file and comparator-mode OS.
// Revision    : 1.0 - initial release
// ============================================================================
module lm75_i2c_target
    import lm75_i2c_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'h48,
    parameter logic [8:0] TOS_RST   = 9'h0A0,
    parameter logic [8:0] THYST_RST = 9'h096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [8:0] temp_in,
    output logic       os_out,
    output logic       busy
);

    logic w_sda_s, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_s     (w_sda_s),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop)
    );

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rw_q, rw_d;
    logic [1:0] ptr_q, ptr_d;
    logic       byte_idx_q, byte_idx_d;
    logic [1:0] wr_idx_q, wr_idx_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] conf_q, conf_d;
    logic [8:0] tos_q, tos_d;
    logic [8:0] thyst_q, thyst_d;
    logic [8:0] shadow_q, shadow_d;
    logic       os_q, os_d;
    logic [7:0] w_byte;
    logic [7:0] w_tx;
    logic       w_idx_next;

    function automatic logic [7:0] read_byte(input logic [1:0] ptr, input logic idx,
                                             input logic [8:0] temp_v, input logic [7:0] conf,
                                             input logic [8:0] thyst, input logic [8:0] tos);
        case (ptr)
            PTR_TEMP:  read_byte = reg9_byte(temp_v, idx);
            PTR_CONF:  read_byte = conf;
            PTR_THYST: read_byte = reg9_byte(thyst, idx);
            default:   read_byte = reg9_byte(tos, idx);
        endcase
    endfunction

    assign w_byte = {shift_q, w_sda_s};

    // Protocol FSM: bit capture on SCL rise, SDA drive changes on SCL fall.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        sda_oe_d   = sda_oe_q;
        rw_d       = rw_q;
        ptr_d      = ptr_q;
        byte_idx_d = byte_idx_q;
        wr_idx_d   = wr_idx_q;
        hold_d     = hold_q;
        conf_d     = conf_q;
        tos_d      = tos_q;
        thyst_d    = thyst_q;
        shadow_d   = shadow_q;
        w_tx       = 8'h00;
        w_idx_next = 1'b0;
        if (w_start) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (w_stop) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: if (w_scl_rise) begin
                    shift_d   = w_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        rw_d      = w_sda_s;
                        state_d   = (w_byte[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IDLE;
                    end
                end
                // ACK states: first fall drives low, second fall ends the ACK slot.
                ST_ADDR_ACK: if (w_scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else if (rw_q) begin
                        if (!conf_q[0]) shadow_d = temp_in;
                        w_tx       = read_byte(ptr_q, 1'b0, shadow_d, conf_q, thyst_q, tos_q);
                        tx_d       = w_tx;
                        sda_oe_d   = ~w_tx[7];
                        byte_idx_d = 1'b0;
                        bit_cnt_d  = 4'd0;
                        state_d    = ST_RDATA;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_PTR;
                    end
                end
                ST_PTR: if (w_scl_rise) begin
                    shift_d   = w_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        ptr_d     = w_byte[1:0];
                        state_d   = ST_PTR_ACK;
                    end
                end
                ST_PTR_ACK, ST_WACK: if (w_scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WDATA;
                        if (state_q == ST_PTR_ACK) wr_idx_d = 2'd0;
                    end
                end
                ST_WDATA: if (w_scl_rise) begin
                    shift_d   = w_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        state_d   = ST_WACK;
                        if (wr_idx_q != 2'd2) wr_idx_d = wr_idx_q + 2'd1;
                        // 9-bit registers commit only once both bytes have arrived.
                        case (ptr_q)
                            PTR_CONF:  if (wr_idx_q == 2'd0) conf_d = w_byte;
                            PTR_THYST: if (wr_idx_q == 2'd0) hold_d = w_byte;
                                       else if (wr_idx_q == 2'd1) thyst_d = reg9_pack(hold_q, w_byte);
                            PTR_TOS:   if (wr_idx_q == 2'd0) hold_d = w_byte;
                                       else if (wr_idx_q == 2'd1) tos_d = reg9_pack(hold_q, w_byte);
                            default: ;
                        endcase
                    end
                end
                ST_RDATA: begin
                    if (w_scl_rise) begin
                        tx_d      = {tx_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (w_scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = ST_RACK;
                        end else begin
                            sda_oe_d = ~tx_q[7];
                        end
                    end
                end
                ST_RACK: begin
                    if (w_scl_rise && w_sda_s) begin
                        state_d = ST_IDLE;
                    end else if (w_scl_fall) begin
                        w_idx_next = (ptr_q == PTR_CONF) ? 1'b0 : ~byte_idx_q;
                        w_tx       = read_byte(ptr_q, w_idx_next, shadow_q, conf_q, thyst_q, tos_q);
                        byte_idx_d = w_idx_next;
                        tx_d       = w_tx;
                        sda_oe_d   = ~w_tx[7];
                        bit_cnt_d  = 4'd0;
                        state_d    = ST_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    // Comparator-mode overtemperature flag with hysteresis on live temperature.
    always_comb begin
        os_d = os_q;
        if ($signed(temp_in) >= $signed(tos_q)) begin
            os_d = 1'b1;
        end else if ($signed(temp_in) < $signed(thyst_q)) begin
            os_d = 1'b0;
        end
    end

    // State registers; reset releases SDA immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 7'd0;
            tx_q       <= 8'd0;
            sda_oe_q   <= 1'b0;
            rw_q       <= 1'b0;
            ptr_q      <= PTR_TEMP;
            byte_idx_q <= 1'b0;
            wr_idx_q   <= 2'd0;
            hold_q     <= 8'd0;
            conf_q     <= 8'h00;
            tos_q      <= TOS_RST;
            thyst_q    <= THYST_RST;
            shadow_q   <= 9'd0;
            os_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            sda_oe_q   <= sda_oe_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            byte_idx_q <= byte_idx_d;
            wr_idx_q   <= wr_idx_d;
            hold_q     <= hold_d;
            conf_q     <= conf_d;
            tos_q      <= tos_d;
            thyst_q    <= thyst_d;
            shadow_q   <= shadow_d;
            os_q       <= os_d;
        end
    end

    assign sda_oe = sda_oe_q;
    assign os_out = os_q ^ conf_q[2];
    assign busy   = (state_q != ST_IDLE) && (state_q != ST_ADDR);

endmodule
`default_nettype wire

// File: tb/tb_lm75_i2c_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lm75_i2c_target
// Description : Bit-banged I2C master driving the LM75 target, with a
//               register-level reference model feeding a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lm75_i2c_target;

    localparam int H = 16;   // SCL half period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [8:0] temp_in = 9'd0;
    logic       sda_oe, os_out, busy;
    logic       sda_bus;

    assign sda_bus = sda_m & ~sda_oe;

    always #20 clk = ~clk;

    lm75_i2c_target dut (
        .clk     (clk),
        .rst     (rst),
        .scl_i   (scl_m),
        .sda_i   (sda_bus),
        .sda_oe  (sda_oe),
        .temp_in (temp_in),
        .os_out  (os_out),
        .busy    (busy)
    );

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];
    string      name_q[$];
    logic [8:0] obs_q[$];
    int         checks = 0;
    int         failures = 0;
    bit         end_req = 1'b0;
    bit         end_ack = 1'b0;
    int         oe_cnt = 0;

    task automatic expect_val(input string nm, input logic [8:0] v);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic observe(input logic [8:0] v);
        obs_q.push_back(v);
    endtask

    initial begin : monitor
        logic [8:0] a, e;
        string nm;
        forever begin
            @(negedge clk);
            while (obs_q.size() > 0) begin
                a = obs_q.pop_front();
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output actual=%0h required=none", a);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (a !== e) begin
                        failures++;
                        $display("FAIL %s actual=%0h required=%0h", nm, a, e);
                    end
                end
            end
            if (end_req && !end_ack) begin
                checks++;
                if (exp_q.size() != 0) begin
                    failures++;
                    $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
                end
                end_ack = 1'b1;
            end
        end
    end

    initial begin : oe_counter
        forever begin
            @(negedge clk);
            if (sda_oe) oe_cnt++;
        end
    end

    initial begin : watchdog
        #3_600_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

    // ---------------- reference model ----------------
    int         m_ptr;
    logic [7:0] m_conf, m_hold;
    logic [8:0] m_tos, m_thyst, m_shadow;
    bit         m_os;

    function automatic int sv(input logic [8:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [7:0] fmt(input logic [8:0] v, input int idx);
        int u;
        u = int'(v);
        return (idx == 0) ? 8'(u / 2) : 8'((u % 2) * 128);
    endfunction

    task automatic model_os();
        if (sv(temp_in) >= sv(m_tos)) m_os = 1'b1;
        else if (sv(temp_in) < sv(m_thyst)) m_os = 1'b0;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_conf = 8'h00; m_hold = 8'h00;
        m_tos = 9'h0A0; m_thyst = 9'h096; m_shadow = 9'd0; m_os = 1'b0;
        model_os();
    endtask

    function automatic logic [7:0] exp_rd(input int i);
        case (m_ptr)
            0:       return fmt(m_shadow, i % 2);
            1:       return m_conf;
            2:       return fmt(m_thyst, i % 2);
            default: return fmt(m_tos, i % 2);
        endcase
    endfunction

    // ---------------- bus master ----------------
    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; clks(H); scl_m = 1'b1; clks(H);
        sda_m = 1'b0; clks(H); scl_m = 1'b0; clks(H);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; clks(H); scl_m = 1'b1; clks(H); sda_m = 1'b1; clks(H);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; clks(H); scl_m = 1'b1; clks(H); scl_m = 1'b0; clks(4);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; clks(H); scl_m = 1'b1; clks(H / 2);
        b = sda_bus; clks(H / 2); scl_m = 1'b0; clks(4);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    task automatic send_ack(input logic [7:0] d, input string nm);
        logic ack;
        expect_val(nm, 9'd0);
        write_byte(d, ack);
        observe({8'd0, ack});
    endtask

    task automatic read_txn(input bit set_ptr, input int p, input int n);
        logic [7:0] d;
        i2c_start();
        if (set_ptr) begin
            send_ack(8'h90, "wr_addr_ack");
            send_ack(8'(p), "ptr_ack");
            m_ptr = p;
            i2c_start();
        end
        send_ack(8'h91, "rd_addr_ack");
        expect_val("busy_read", 9'd1);
        observe({8'd0, busy});
        if (!m_conf[0]) m_shadow = temp_in;
        for (int i = 0; i < n; i++) begin
            expect_val("rd_byte", {1'b0, exp_rd(i)});
            read_byte(d, (i == n - 1));
            observe({1'b0, d});
        end
        expect_val("sda_after_nack", 9'd0);
        observe({8'd0, sda_oe});
        i2c_stop();
        expect_val("busy_after_stop", 9'd0);
        observe({8'd0, busy});
    endtask

    task automatic write_txn(input int p, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int n);
        logic [7:0] b;
        i2c_start();
        send_ack(8'h90, "wr_addr_ack");
        send_ack(8'(p), "ptr_ack");
        m_ptr = p;
        for (int i = 0; i < n; i++) begin
            b = (i == 0) ? b0 : (i == 1) ? b1 : b2;
            send_ack(b, "wr_data_ack");
            if (p == 1 && i == 0) m_conf = b;
            if (p >= 2 && i == 0) m_hold = b;
            if (p == 2 && i == 1) m_thyst = {m_hold, b[7]};
            if (p == 3 && i == 1) m_tos = {m_hold, b[7]};
        end
        i2c_stop();
        model_os();
    endtask

    task automatic check_os();
        clks(3);
        expect_val("os_out", {8'd0, m_os ^ m_conf[2]});
        observe({8'd0, os_out});
    endtask

    task automatic set_temp(input logic [8:0] v);
        temp_in = v;
        model_os();
        check_os();
    endtask

    task automatic os_ramp();
        for (int t = 148; t <= 162; t += 2) set_temp(9'(t));
        for (int t = 160; t >= 150; t -= 2) set_temp(9'(t));
        set_temp(9'd149);
        set_temp(9'd148);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        logic ack, b;
        int base, op, p, vi;
        logic [8:0] v;

        model_reset();
        clks(5);
        expect_val("rst_sda_oe", 9'd0); observe({8'd0, sda_oe});
        expect_val("rst_busy", 9'd0);   observe({8'd0, busy});
        expect_val("rst_os_out", 9'd0); observe({8'd0, os_out});
        rst = 1'b1;
        clks(5);

        // pointer-0 temperature read
        temp_in = 9'h032; model_os();
        read_txn(1'b0, 0, 2);

        // TOS write and read back
        write_txn(3, 8'h28, 8'h80, 8'h00, 2);
        read_txn(1'b0, 3, 2);
        check_os();

        // wrong address: no SDA drive at all
        base = oe_cnt;
        i2c_start();
        expect_val("wrong_addr_ack", 9'd1);
        write_byte(8'h94, ack);
        observe({8'd0, ack});
        write_byte(8'h00, ack);
        expect_val("wrong_addr_busy", 9'd0); observe({8'd0, busy});
        i2c_stop();
        expect_val("wrong_addr_oe_cycles", 9'd0);
        observe((oe_cnt != base) ? 9'd1 : 9'd0);

        // repeated START with byte wrap on TEMP
        temp_in = 9'h1FF; model_os();
        read_txn(1'b1, 0, 3);

        // reset in the middle of a read byte
        temp_in = 9'h000; model_os();
        i2c_start();
        send_ack(8'h91, "rd_addr_ack");
        if (!m_conf[0]) m_shadow = temp_in;
        read_bit(b);
        sda_m = 1'b1; clks(H); scl_m = 1'b1; clks(H / 2);
        expect_val("rdata_drive_zero", 9'd1); observe({8'd0, sda_oe});
        rst = 1'b0;
        #1;
        expect_val("async_rst_release", 9'd0); observe({8'd0, sda_oe});
        clks(3);
        rst = 1'b1;
        model_reset();
        scl_m = 1'b0; clks(H);
        i2c_stop();
        temp_in = 9'h032; model_os();
        read_txn(1'b0, 0, 2);

        // partial THYST write leaves register unchanged
        write_txn(2, 8'h10, 8'h00, 8'h00, 1);
        read_txn(1'b1, 2, 2);

        // hysteresis ramp, normal then inverted polarity
        os_ramp();
        write_txn(1, 8'h04, 8'h00, 8'h00, 1);
        check_os();
        os_ramp();
        write_txn(1, 8'h00, 8'h00, 8'h00, 1);

        // randomized register traffic against the model
        for (int it = 0; it < 12; it++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: set_temp(9'($urandom));
                1: read_txn(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
                2: write_txn(1, 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(1, 2)));
                default: begin
                    p = int'($urandom_range(2, 3));
                    if (p == 3) begin
                        vi = sv(m_thyst) + 1 + int'($urandom_range(0, 60));
                        if (vi > 255) vi = 255;
                    end else begin
                        vi = sv(m_tos) - 1 - int'($urandom_range(0, 60));
                        if (vi < -256) vi = -256;
                    end
                    v = 9'(vi);
                    write_txn(p, fmt(v, 0), fmt(v, 1) | 8'($urandom_range(0, 127)),
                              8'($urandom), int'($urandom_range(1, 3)));
                end
            endcase
            check_os();
        end

        clks(4);
        end_req = 1'b1;
        for (int i = 0; i < 20 && !end_ack; i++) clks(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
